// File: rtl/max7219_serial_driver.sv
// MAX7219 serial link driver: sends a fixed power-up init sequence, then
// shifts user {addr, data} words out MSB first with a LOAD pulse per word.
module max7219_serial_driver #(
  parameter int unsigned CLK_DIV        = 2,
  parameter logic [3:0]  INIT_INTENSITY = 4'h8
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [3:0] i_addr,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_ready,
  output logic       o_init_done,
  output logic       o_serial_din,
  output logic       o_serial_load,
  output logic       o_serial_clk
);

  typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH, GAP} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  // The IDLE cycle that follows (or the accept cycle that precedes) a frame is
  // output-identical to GAP, so GAP itself holds one cycle less than CLK_DIV.
  localparam logic [7:0] GAP_LAST = (CLK_DIV > 1) ? 8'(CLK_DIV - 2) : 8'd0;

  state_t      state_q;
  logic [7:0]  hp_cnt_q;
  logic [3:0]  bit_cnt_q;
  logic [2:0]  init_idx_q;
  logic [14:0] shift_q;
  logic        ready_q;
  logic        init_done_q;
  logic        din_q;
  logic        load_q;
  logic        sclk_q;

  logic [15:0] init_word;
  logic [15:0] start_word;
  logic        phase_end;
  logic        frame_end;
  logic        start;

  always_comb begin
    init_word = 16'h0F00;
    case (init_idx_q)
      3'd0:    init_word = 16'h09FF;
      3'd1:    init_word = {4'h0, 4'hA, 4'h0, INIT_INTENSITY};
      3'd2:    init_word = 16'h0B07;
      3'd3:    init_word = 16'h0C01;
      default: init_word = 16'h0F00;
    endcase
  end

  assign phase_end  = (hp_cnt_q == DIV_LAST);
  assign frame_end  = ((state_q == GAP) && (hp_cnt_q == GAP_LAST)) ||
                      ((state_q == LATCH) && phase_end && (CLK_DIV == 1));
  assign start      = (state_q == IDLE) && (!init_done_q || (i_valid && ready_q));
  assign start_word = init_done_q ? {4'h0, i_addr, i_data} : init_word;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= IDLE;
      hp_cnt_q    <= '0;
      bit_cnt_q   <= '0;
      init_idx_q  <= '0;
      shift_q     <= '0;
      ready_q     <= 1'b0;
      init_done_q <= 1'b0;
      din_q       <= 1'b0;
      load_q      <= 1'b1;
      sclk_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= SHIFT_LO;
            shift_q   <= start_word[14:0];
            din_q     <= start_word[15];
            load_q    <= 1'b0;
            sclk_q    <= 1'b0;
            ready_q   <= 1'b0;
            hp_cnt_q  <= '0;
            bit_cnt_q <= '0;
          end
        end
        SHIFT_LO: begin
          if (phase_end) begin
            hp_cnt_q <= '0;
            sclk_q   <= 1'b1;
            state_q  <= SHIFT_HI;
          end else begin
            hp_cnt_q <= hp_cnt_q + 8'd1;
          end
        end
        SHIFT_HI: begin
          if (phase_end) begin
            hp_cnt_q <= '0;
            sclk_q   <= 1'b0;
            if (bit_cnt_q == 4'd15) begin
              din_q   <= 1'b0;
              state_q <= LATCH;
            end else begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
              din_q     <= shift_q[14];
              shift_q   <= {shift_q[13:0], 1'b0};
              state_q   <= SHIFT_LO;
            end
          end else begin
            hp_cnt_q <= hp_cnt_q + 8'd1;
          end
        end
        LATCH: begin
          if (phase_end) begin
            hp_cnt_q <= '0;
            load_q   <= 1'b1;
            state_q  <= GAP;
          end else begin
            hp_cnt_q <= hp_cnt_q + 8'd1;
          end
        end
        GAP: begin
          hp_cnt_q <= hp_cnt_q + 8'd1;
        end
        default: state_q <= IDLE;
      endcase

      if (frame_end) begin
        state_q  <= IDLE;
        hp_cnt_q <= '0;
        if (!init_done_q) begin
          if (init_idx_q == 3'd4) begin
            init_done_q <= 1'b1;
            ready_q     <= 1'b1;
          end else begin
            init_idx_q <= init_idx_q + 3'd1;
          end
        end else begin
          ready_q <= 1'b1;
        end
      end
    end
  end

  assign o_ready       = ready_q;
  assign o_init_done   = init_done_q;
  assign o_serial_din  = din_q;
  assign o_serial_load = load_q;
  assign o_serial_clk  = sclk_q;

endmodule

// File: doc/max7219_serial_driver.md
MAX7219_SERIAL_DRIVER -- requirements
Module: max7219_serial_driver

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, meaning system clocks per serial-clock half-period (legal range 1..255).
REQ-002 SHALL have parameter INIT_INTENSITY, default 4'h8, meaning the intensity value sent during power-up initialisation.
REQ-003 SHALL have port i_clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port i_reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port i_addr  input  4  register address of the word to send.
REQ-006 SHALL have port i_data  input  8  register data of the word to send.
REQ-007 SHALL have port i_valid  input  1  word request; transfer occurs on a cycle with i_valid && o_ready.
REQ-008 SHALL have port o_ready  output  1  driver idle, initialised, and able to accept a word.
REQ-009 SHALL have port o_init_done  output  1  power-up init sequence complete; sticky until reset.
REQ-010 SHALL have port o_serial_din  output  1  MAX7219 DIN.
REQ-011 SHALL have port o_serial_load  output  1  MAX7219 LOAD/CS; the device latches on its rising edge.
REQ-012 SHALL have port o_serial_clk  output  1  MAX7219 CLK; the device samples DIN on its rising edge.

Function
REQ-013 SHALL format each frame as 16 bits, MSB first: {4'h0, addr[3:0], data[7:0]}.
REQ-014 SHALL use an FSM with states IDLE, SHIFT_LO, SHIFT_HI, LATCH, GAP, and an init-word index of 0..4.
REQ-015 SHALL, on accept (IDLE, i_valid && o_ready), capture addr/data into a shift register; later input changes SHALL NOT affect the frame.
REQ-016 SHALL drive o_serial_load=0, o_serial_clk=0, o_serial_din=bit15 starting the cycle after accept (SHIFT_LO).
REQ-017 SHALL hold SHIFT_LO for CLK_DIV cycles, then SHIFT_HI (o_serial_clk=1) for CLK_DIV cycles; DIN SHALL change only on entry to SHIFT_LO.
REQ-018 SHALL repeat SHIFT_LO/SHIFT_HI for 16 bits, counted by a 4-bit bit counter, then enter LATCH.
REQ-019 SHALL hold LATCH (load=0, clk=0, din=0) for CLK_DIV cycles, then enter GAP with o_serial_load=1.
REQ-020 SHALL hold GAP (load=1, clk=0, din=0) for CLK_DIV cycles, then return to IDLE.
REQ-021 SHALL take exactly 34*CLK_DIV cycles from the accept cycle to o_ready re-asserting (68 cycles at CLK_DIV=2).
REQ-022 SHALL assert o_ready only in IDLE with o_init_done=1; i_valid while o_ready=0 SHALL be ignored without queuing.
REQ-023 SHALL, after reset, autonomously send 5 init frames in order: 0x09FF, 0x0A0 with INIT_INTENSITY, 0x0B07, 0x0C01, 0x0F00.
REQ-024 SHALL start the first init frame in the cycle after reset deasserts, with back-to-back frames (no idle cycles between GAP and the next SHIFT_LO).
REQ-025 SHALL set o_init_done=1 on the cycle the last init frame's GAP completes (5*34*CLK_DIV cycles after reset release).
REQ-026 SHALL, outside frames, idle with load=1, clk=0, din=0.
REQ-027 SHALL keep the half-period counter wide enough for CLK_DIV-1 and wrap it to 0 on each phase change.

Reset
REQ-028 SHALL, while i_reset=1, drive o_serial_load=1, o_serial_clk=0, o_serial_din=0, o_ready=0, o_init_done=0, FSM=IDLE, and clear the counters and init index.
REQ-029 SHALL abort any in-progress frame on reset (no LOAD rising edge is produced by the abort beyond the idle-high level) and restart the init sequence after release.
REQ-030 SHALL give reset priority over a simultaneous i_valid.

Verification
REQ-031 SHALL verify init: release reset with the MAX7219 mock attached -> after 340 cycles (CLK_DIV=2) o_init_done=1, o_ready=1, and the mock reports decode_mode=0xFF, scan_limit=7, enable=1, intensity=8.
REQ-032 SHALL verify a single write: after init, send addr=1, data=0x05 -> mock digit0=0x05, o_ready low for exactly 67 cycles and high on cycle 68.
REQ-033 SHALL verify serial timing: capture DIN on each rising o_serial_clk edge during a frame with addr=8, data=0xA5 -> 16 bits read 0x08A5, with exactly 16 clk rising edges and one load rising edge.
REQ-034 SHALL verify backpressure: hold i_valid=1 with changing data during a frame -> only words present on accept cycles are sent; no extra frames occur.
REQ-035 SHALL verify reset mid-frame: assert i_reset at bit 7 of a user frame -> next cycle load=1, clk=0; the targeted mock digit is unchanged; the init sequence reruns.
REQ-036 SHALL verify CLK_DIV=1: 8 consecutive digit writes -> all mock digits are correct, with each frame lasting 34 cycles.
